// File: rtl/approx_errmon_pkg.sv
// Shared types and defaults for the approximate-adder error monitor.
// The optional max-ED tracker is enabled by defining APPROX_ERRMON_MAXED_EN.
package approx_errmon_pkg;

  localparam int unsigned DEF_WIDTH        = 32;
  localparam int unsigned DEF_SAMPLES_LOG2 = 10;
  localparam int unsigned DEF_SUM_W        = 48;

  // Cycles between the last accepted sample and DONE; matches the two pipeline stages.
  localparam int unsigned DRAIN_LEN = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/error_distance_unit.sv
// Combinational absolute difference |exact - approx| with a mismatch flag.
module error_distance_unit #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] exact_i,
  input  logic [W-1:0] approx_i,
  output logic [W-1:0] ed_o,
  output logic         mismatch_o
);

  always_comb begin
    if (exact_i >= approx_i) ed_o = exact_i - approx_i;
    else                     ed_o = approx_i - exact_i;
  end

  assign mismatch_o = |ed_o;

endmodule

// File: rtl/approx_error_monitor32.sv
// Windowed error-statistics collector for 32-bit approximate adders.
// Define APPROX_ERRMON_MAXED_EN to compile in the max-ED tracker; otherwise ed_max_o is 0.
module approx_error_monitor32
  import approx_errmon_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned SAMPLES_LOG2 = DEF_SAMPLES_LOG2,
  parameter int unsigned SUM_W        = DEF_SUM_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    valid_i,
  input  logic [WIDTH-1:0]        add1_i,
  input  logic [WIDTH-1:0]        add2_i,
  input  logic [WIDTH:0]          approx_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [SAMPLES_LOG2:0]   sample_cnt_o,
  output logic [SAMPLES_LOG2:0]   err_cnt_o,
  output logic [SUM_W-1:0]        ed_sum_o,
  output logic [WIDTH:0]          ed_max_o
);

  localparam int unsigned CNT_W   = SAMPLES_LOG2 + 1;
  localparam int unsigned ED_W    = WIDTH + 1;
  localparam int unsigned DRAIN_W = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  localparam logic [CNT_W-1:0]   WINDOW     = {1'b1, {SAMPLES_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0]   LAST_IDX   = {1'b0, {SAMPLES_LOG2{1'b1}}};
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);
  localparam logic [SUM_W-1:0]   SUM_SAT    = {SUM_W{1'b1}};

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 done_q, done_d;

  logic                 s1_valid_q, s1_valid_d;
  logic [ED_W-1:0]      s1_exact_q, s1_exact_d;
  logic [ED_W-1:0]      s1_approx_q, s1_approx_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [ED_W-1:0]      s2_ed_q, s2_ed_d;
  logic                 s2_mis_q, s2_mis_d;

  logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0]     ed_sum_q, ed_sum_d;

  logic                 accept;
  logic                 clear;
  logic [ED_W-1:0]      ed_w;
  logic                 mis_w;
  logic [SUM_W:0]       sum_ext;

  // NOTE: every signal driven in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : ctrl_comb
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    accept      = 1'b0;
    clear       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = RUN;
          acc_cnt_d = '0;
          clear     = 1'b1;
        end
      end
      RUN: begin
        if (valid_i && (acc_cnt_q < WINDOW)) begin
          accept    = 1'b1;
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == LAST_IDX) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  error_distance_unit #(.W(ED_W)) u_edu (
    .exact_i    (s1_exact_q),
    .approx_i   (s1_approx_q),
    .ed_o       (ed_w),
    .mismatch_o (mis_w)
  );

  always_comb begin : dp_comb
    s1_valid_d  = accept;
    s1_exact_d  = s1_exact_q;
    s1_approx_d = s1_approx_q;
    if (accept) begin
      s1_exact_d  = {1'b0, add1_i} + {1'b0, add2_i};
      s1_approx_d = approx_i;
    end

    s2_valid_d = s1_valid_q && !clear;
    s2_ed_d    = s2_ed_q;
    s2_mis_d   = s2_mis_q;
    if (s1_valid_q) begin
      s2_ed_d  = ed_w;
      s2_mis_d = mis_w;
    end

    // One extra bit catches the carry out so the sum saturates instead of wrapping.
    sum_ext      = {1'b0, ed_sum_q} + {{(SUM_W - WIDTH){1'b0}}, s2_ed_q};
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    ed_sum_d     = ed_sum_q;
    if (clear) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      ed_sum_d     = '0;
    end else if (s2_valid_q) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      err_cnt_d    = err_cnt_q + CNT_W'(s2_mis_q);
      ed_sum_d     = sum_ext[SUM_W] ? SUM_SAT : sum_ext[SUM_W-1:0];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values; the async reset clears datapath flops too, as all outputs must read 0 in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      acc_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      done_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_exact_q   <= '0;
      s1_approx_q  <= '0;
      s2_valid_q   <= 1'b0;
      s2_ed_q      <= '0;
      s2_mis_q     <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      ed_sum_q     <= '0;
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      done_q       <= done_d;
      s1_valid_q   <= s1_valid_d;
      s1_exact_q   <= s1_exact_d;
      s1_approx_q  <= s1_approx_d;
      s2_valid_q   <= s2_valid_d;
      s2_ed_q      <= s2_ed_d;
      s2_mis_q     <= s2_mis_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ed_sum_q     <= ed_sum_d;
    end
  end

`ifdef APPROX_ERRMON_MAXED_EN
  logic [ED_W-1:0] ed_max_q, ed_max_d;

  always_comb begin : max_comb
    ed_max_d = ed_max_q;
    if (clear)                                  ed_max_d = '0;
    else if (s2_valid_q && (s2_ed_q > ed_max_q)) ed_max_d = s2_ed_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ed_max_q <= '0;
    else       ed_max_q <= ed_max_d;
  end

  assign ed_max_o = ed_max_q;
`else
  assign ed_max_o = '0;
`endif

  assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
  assign done_o       = done_q;
  assign sample_cnt_o = sample_cnt_q;
  assign err_cnt_o    = err_cnt_q;
  assign ed_sum_o     = ed_sum_q;

endmodule

// File: tb/tb_approx_error_monitor32.sv
// Self-checking bench for approx_error_monitor32 with a 4-sample window and a 34-bit ED sum.
module tb_approx_error_monitor32;

  localparam int WIDTH = 32;
  localparam int SLOG2 = 2;
  localparam int SUM_W = 34;
`ifdef APPROX_ERRMON_MAXED_EN
  localparam bit MAXED = 1'b1;
`else
  localparam bit MAXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              valid_i;
  logic [WIDTH-1:0]  add1_i;
  logic [WIDTH-1:0]  add2_i;
  logic [WIDTH:0]    approx_i;
  logic              busy_o;
  logic              done_o;
  logic [SLOG2:0]    sample_cnt_o;
  logic [SLOG2:0]    err_cnt_o;
  logic [SUM_W-1:0]  ed_sum_o;
  logic [WIDTH:0]    ed_max_o;

  approx_error_monitor32 #(
    .WIDTH(WIDTH), .SAMPLES_LOG2(SLOG2), .SUM_W(SUM_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i),
    .add1_i(add1_i), .add2_i(add2_i), .approx_i(approx_i),
    .busy_o(busy_o), .done_o(done_o), .sample_cnt_o(sample_cnt_o),
    .err_cnt_o(err_cnt_o), .ed_sum_o(ed_sum_o), .ed_max_o(ed_max_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] a1;
    logic [3:0][31:0] a2;
    logic [3:0][32:0] ap;
    bit               gaps;
    logic [2:0]       e_err;
    logic [33:0]      e_sum;
    logic [32:0]      e_max;
  } vec_t;

  typedef struct {
    logic [2:0]  cnt;
    logic [2:0]  err;
    logic [33:0] sum;
    logic [32:0] max;
  } exp_t;

  vec_t vecs[5];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_s(input int r, input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] ap);
    vecs[r].a1[k] = a;
    vecs[r].a2[k] = b;
    vecs[r].ap[k] = ap;
  endtask

  task automatic drive_junk(input logic v);
    valid_i  = v;
    add1_i   = 32'hFFFF_FFFF;
    add2_i   = 32'h1234_5678;
    approx_i = 33'h0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic apply_window(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    int   n;
    e.cnt = 3'd4;
    e.err = v.e_err;
    e.sum = v.e_sum;
    e.max = MAXED ? v.e_max : 33'h0;
    sb_q.push_back(e);

    drive_junk(1'b0);
    pulse_start();
    check({tag, "_start_busy"}, 64'(busy_o), 64'd1);
    check({tag, "_start_clr_cnt"}, 64'(sample_cnt_o), 64'd0);
    check({tag, "_start_clr_sum"}, 64'(ed_sum_o), 64'd0);

    for (int k = 0; k < 4; k++) begin
      if (v.gaps && k > 0) begin
        drive_junk(1'b0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
      end
      valid_i  = 1'b1;
      add1_i   = v.a1[k];
      add2_i   = v.a2[k];
      approx_i = v.ap[k];
      @(negedge clk);
    end

    // Junk samples keep arriving through DRAIN and DONE and must be ignored.
    drive_junk(1'b1);
    n = 0;
    while (!done_o && n < 9) begin
      check({tag, "_busy_drain"}, 64'(busy_o), 64'd1);
      @(negedge clk);
      n++;
    end
    check({tag, "_done_latency"}, 64'(n), 64'd2);

    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      got = sb_q.pop_front();
      check({tag, "_sample_cnt"}, 64'(sample_cnt_o), 64'(got.cnt));
      check({tag, "_err_cnt"}, 64'(err_cnt_o), 64'(got.err));
      check({tag, "_ed_sum"}, 64'(ed_sum_o), 64'(got.sum));
      check({tag, "_ed_max"}, 64'(ed_max_o), 64'(got.max));
      check({tag, "_done_busy"}, 64'(busy_o), 64'd0);
    end

    @(negedge clk);
    check({tag, "_done_pulse_end"}, 64'(done_o), 64'd0);
    check({tag, "_hold_cnt"}, 64'(sample_cnt_o), 64'd4);
    check({tag, "_hold_sum"}, 64'(ed_sum_o), 64'(e.sum));
    drive_junk(1'b0);
  endtask

  initial begin
    int done_seen;

    set_s(0, 0, 32'h29AF2430, 32'h7A1B9ABC, 33'h0A3CABEEC);
    for (int k = 1; k < 4; k++) set_s(0, k, 32'h29AF2430, 32'h7A1B9ABC, 33'h0A3CABEEC);
    vecs[0].gaps = 1'b0; vecs[0].e_err = 3'd0; vecs[0].e_sum = 34'h0;  vecs[0].e_max = 33'h0;

    for (int k = 0; k < 4; k++) set_s(1, k, 32'h29AF2430, 32'h7A1B9ABC, 33'h0A3CABEE0);
    vecs[1].gaps = 1'b0; vecs[1].e_err = 3'd4; vecs[1].e_sum = 34'h30; vecs[1].e_max = 33'hC;

    for (int k = 0; k < 4; k++) set_s(2, k, 32'h55555555, 32'hAAAAAAAA, 33'h0FFFFFFFF);
    set_s(2, 1, 32'h55555555, 32'hAAAAAAAA, 33'h100000003);
    vecs[2].gaps = 1'b0; vecs[2].e_err = 3'd1; vecs[2].e_sum = 34'h4;  vecs[2].e_max = 33'h4;

    for (int k = 0; k < 4; k++) set_s(3, k, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0);
    vecs[3].gaps = 1'b0; vecs[3].e_err = 3'd4; vecs[3].e_sum = 34'h3FFFFFFFF;
    vecs[3].e_max = 33'h1FFFFFFFE;

    set_s(4, 0, 32'h0,        32'h0,        33'h000000001);
    set_s(4, 1, 32'hFFFFFFFF, 32'h1,        33'h100000000);
    set_s(4, 2, 32'd10,       32'd20,       33'd25);
    set_s(4, 3, 32'h80000000, 32'h80000000, 33'h0FFFFFFF0);
    vecs[4].gaps = 1'b1; vecs[4].e_err = 3'd3; vecs[4].e_sum = 34'h16; vecs[4].e_max = 33'h10;

    rst_i   = 1'b1;
    start_i = 1'b0;
    drive_junk(1'b0);
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_cnt", 64'(sample_cnt_o), 64'd0);
    check("rst_sum", 64'(ed_sum_o), 64'd0);
    rst_i = 1'b0;
    drive_junk(1'b1);
    repeat (3) @(negedge clk);
    check("idle_ignores_valid", 64'(sample_cnt_o), 64'd0);
    check("idle_busy", 64'(busy_o), 64'd0);

    apply_window(vecs[0], "exact");
    apply_window(vecs[1], "below");
    apply_window(vecs[2], "above");
    apply_window(vecs[3], "sat");
    apply_window(vecs[4], "gaps");

    pulse_start();
    for (int k = 0; k < 2; k++) begin
      valid_i  = 1'b1;
      add1_i   = vecs[1].a1[k];
      add2_i   = vecs[1].a2[k];
      approx_i = vecs[1].ap[k];
      @(negedge clk);
    end
    drive_junk(1'b0);
    repeat (2) @(negedge clk);
    check("mid_cnt", 64'(sample_cnt_o), 64'd2);
    check("mid_err", 64'(err_cnt_o), 64'd2);
    rst_i = 1'b1;
    #1;
    check("mid_rst_cnt", 64'(sample_cnt_o), 64'd0);
    check("mid_rst_err", 64'(err_cnt_o), 64'd0);
    check("mid_rst_sum", 64'(ed_sum_o), 64'd0);
    check("mid_rst_max", 64'(ed_max_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    check("mid_rst_no_done", 64'(done_seen), 64'd0);
    check("mid_rst_idle", 64'(busy_o), 64'd0);

    apply_window(vecs[1], "post_rst");

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
